en_serial_tx: RTL and testbench
===============================

Name: en_serial_tx

Overview:
Parallel-to-serial transmitter that drives the data/enable pair of an enabled D flip-flop capture chain.
- Accepts a WIDTH-bit word over a valid/ready handshake.
- Shifts the word out one bit per CLK cycle on SD, with SEN high for each valid bit.
- Downstream enabled flops capture SD only when SEN=1.
- Sits between a word source and any enable-gated serial receiver in the design.

Parameters:
WIDTH, 8, data word width in bits (>=2).
GAP, 1, idle cycles (SEN=0) forced between consecutive words (0..15).
MSB_FIRST, 1, 1 = bit WIDTH-1 sent first; 0 = bit 0 sent first.

Ports:
CLK  input  1  rising-edge clock.
RST  input  1  synchronous, active-high reset.
DIN  input  WIDTH  parallel word to transmit.
LOAD_VALID  input  1  source presents DIN.
LOAD_READY  output  1  block can accept a word this cycle.
SD  output  1  serial data bit.
SEN  output  1  bit-valid strobe for downstream enabled flops.
BUSY  output  1  high from the accepting edge until the last bit (or last gap cycle) completes.
DONE  output  1  one-cycle pulse in the cycle after the final bit of a word.

Behaviour:
- All outputs are registered.
- Reset (RST=1 at a CLK edge): state=IDLE, SD=0, SEN=0, BUSY=0, DONE=0, LOAD_READY=1, bit counter=0, gap counter=0.
- Reset mid-word aborts the word immediately; no further SEN pulses occur.
- Transfer rule: a word is accepted on any edge where LOAD_VALID && LOAD_READY. DIN is latched into the shift register on that edge.
- LOAD_READY=1 only in IDLE. It drops on the accepting edge.
- State IDLE: SEN=0, SD holds its last value.
  - On accept -> SHIFT, counter=0.
- State SHIFT: one bit per cycle.
  - First bit appears on SD with SEN=1 in the cycle immediately after the accept edge (latency 1).
  - Bit order follows MSB_FIRST.
  - Counter increments each cycle.
  - After bit WIDTH-1 is presented: if GAP=0 -> IDLE, else -> GAP.
  - A word therefore occupies exactly WIDTH consecutive SEN=1 cycles, with no bubbles.
- State GAP: SEN=0 for exactly GAP cycles, then -> IDLE.
- DONE: pulses for one cycle in the first cycle after the final bit (SEN already 0).
- BUSY: clears when LOAD_READY returns to 1.
- Back-to-back throughput with GAP=0: an accept occurs in the IDLE cycle after SHIFT. Minimum word period is WIDTH+1 cycles (one IDLE cycle always separates words). With GAP=g the period is WIDTH+g+1.
- LOAD_VALID high while not ready: ignored; DIN is not sampled.
- DIN changing during SHIFT has no effect.
- Counter width is clog2(WIDTH+1); there is no wrap beyond WIDTH.

Optional Feature:
Macro PARITY_EN.
- Defined: after the WIDTH data bits, one extra SHIFT cycle drives the even-parity bit (XOR of all latched data bits) with SEN=1. The word occupies WIDTH+1 SEN cycles, and DONE/GAP timing shifts one cycle later.
- Undefined: no parity cycle; exactly WIDTH SEN cycles per word. No parity logic is synthesized.

Test Plan:
- Reset: hold RST=1 for 2 cycles mid-SHIFT of 8'hA5 -> next cycle SEN=0, BUSY=0, LOAD_READY=1, DONE=0; no further SEN pulses.
- Single word, WIDTH=8, MSB_FIRST=1, GAP=1, DIN=8'hA5 accepted at cycle t:
  - SD=1,0,1,0,0,1,0,1 with SEN=1 on cycles t+1..t+8.
  - SEN=0 on t+9, DONE=1 on t+9, LOAD_READY=1 on t+10.
- LSB first, MSB_FIRST=0, DIN=8'h01 -> SD=1 then seven 0s on consecutive SEN cycles.
- Back-to-back, GAP=0, LOAD_VALID held high with 8'hFF then 8'h00:
  - 8 ones with SEN=1, then exactly 1 cycle SEN=0, then 8 zeros with SEN=1.
  - DIN changes during SHIFT are not transmitted.
- Handshake stall: LOAD_VALID=1 asserted during SHIFT -> no accept until LOAD_READY=1; LOAD_READY never high while BUSY=1.
- PARITY_EN defined, DIN=8'h07 -> 9 SEN=1 cycles, 9th bit SD=1 (odd popcount 3 -> parity 1); DIN=8'h03 -> 9th bit SD=0.

Source files
------------

// File: rtl/en_serial_tx.sv
// Parallel-to-serial transmitter driving the SD/SEN pair of an enabled-flop chain.
// Optional macro PARITY_EN appends an even-parity bit after the data bits.
module en_serial_tx #(
    parameter int WIDTH     = 8,
    parameter int GAP       = 1,
    parameter int MSB_FIRST = 1
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [WIDTH-1:0] DIN,
    input  logic             LOAD_VALID,
    output logic             LOAD_READY,
    output logic             SD,
    output logic             SEN,
    output logic             BUSY,
    output logic             DONE
);

    localparam int CW = $clog2(WIDTH + 1);
`ifdef PARITY_EN
    localparam int NBITS = WIDTH + 1;
`else
    localparam int NBITS = WIDTH;
`endif
    localparam logic [CW-1:0] LAST = CW'(NBITS - 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SHIFT = 2'd1;
    localparam logic [1:0] S_GAP   = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] sr_q, sr_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [3:0]       gcnt_q, gcnt_d;
    logic             sd_q, sd_d;
    logic             sen_q, sen_d;
    logic             done_q, done_d;
    logic             ready_q, ready_d;
    logic             busy_q, busy_d;
    logic             accept;
    logic             first_bit;
    logic             next_bit;
    logic [WIDTH-1:0] din_shifted;
    logic [WIDTH-1:0] sr_shifted;
`ifdef PARITY_EN
    logic             par_q, par_d;
`endif

    assign accept = LOAD_VALID && ready_q;

    // Bit selection and shift direction are fixed by MSB_FIRST.
    always_comb begin
        if (MSB_FIRST != 0) begin
            first_bit   = DIN[WIDTH-1];
            next_bit    = sr_q[WIDTH-1];
            din_shifted = DIN << 1;
            sr_shifted  = sr_q << 1;
        end else begin
            first_bit   = DIN[0];
            next_bit    = sr_q[0];
            din_shifted = DIN >> 1;
            sr_shifted  = sr_q >> 1;
        end
    end

    always_comb begin
        state_d = state_q;
        sr_d    = sr_q;
        cnt_d   = cnt_q;
        gcnt_d  = gcnt_q;
        sd_d    = sd_q;
        sen_d   = 1'b0;
        done_d  = 1'b0;
        ready_d = ready_q;
        busy_d  = busy_q;
`ifdef PARITY_EN
        par_d   = par_q;
`endif
        unique case (state_q)
            S_IDLE: begin
                if (accept) begin
                    state_d = S_SHIFT;
                    cnt_d   = '0;
                    sd_d    = first_bit;
                    sr_d    = din_shifted;
                    sen_d   = 1'b1;
                    ready_d = 1'b0;
                    busy_d  = 1'b1;
`ifdef PARITY_EN
                    par_d   = ^DIN;
`endif
                end
            end
            S_SHIFT: begin
                if (cnt_q == LAST) begin
                    done_d = 1'b1;
                    cnt_d  = '0;
                    if (GAP == 0) begin
                        state_d = S_IDLE;
                        ready_d = 1'b1;
                        busy_d  = 1'b0;
                    end else begin
                        state_d = S_GAP;
                        gcnt_d  = 4'(GAP - 1);
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                    sen_d = 1'b1;
                    sr_d  = sr_shifted;
                    sd_d  = next_bit;
`ifdef PARITY_EN
                    if (cnt_q == CW'(NBITS - 2)) begin
                        sd_d = par_q;
                    end
`endif
                end
            end
            S_GAP: begin
                if (gcnt_q == 4'd0) begin
                    state_d = S_IDLE;
                    ready_d = 1'b1;
                    busy_d  = 1'b0;
                end else begin
                    gcnt_d = gcnt_q - 4'd1;
                end
            end
            default: begin
                state_d = S_IDLE;
                ready_d = 1'b1;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= S_IDLE;
            sr_q    <= '0;
            cnt_q   <= '0;
            gcnt_q  <= '0;
            sd_q    <= 1'b0;
            sen_q   <= 1'b0;
            done_q  <= 1'b0;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
`ifdef PARITY_EN
            par_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            sr_q    <= sr_d;
            cnt_q   <= cnt_d;
            gcnt_q  <= gcnt_d;
            sd_q    <= sd_d;
            sen_q   <= sen_d;
            done_q  <= done_d;
            ready_q <= ready_d;
            busy_q  <= busy_d;
`ifdef PARITY_EN
            par_q   <= par_d;
`endif
        end
    end

    assign LOAD_READY = ready_q;
    assign SD         = sd_q;
    assign SEN        = sen_q;
    assign BUSY       = busy_q;
    assign DONE       = done_q;

endmodule

// File: tb/tb_en_serial_tx.sv
// Directed bench for en_serial_tx: three instances cover MSB/GAP=1,
// LSB/GAP=1 and MSB/GAP=0 back-to-back operation.
module tb_en_serial_tx;

`ifdef PARITY_EN
    localparam int NB = 9;
`else
    localparam int NB = 8;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [2:0] lv  = '0;
    logic [7:0] din [3];
    logic [2:0] rdy, sd, sen, busy, done;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    en_serial_tx #(.WIDTH(8), .GAP(1), .MSB_FIRST(1)) u0 (
        .CLK(clk), .RST(rst), .DIN(din[0]), .LOAD_VALID(lv[0]),
        .LOAD_READY(rdy[0]), .SD(sd[0]), .SEN(sen[0]),
        .BUSY(busy[0]), .DONE(done[0]));

    en_serial_tx #(.WIDTH(8), .GAP(1), .MSB_FIRST(0)) u1 (
        .CLK(clk), .RST(rst), .DIN(din[1]), .LOAD_VALID(lv[1]),
        .LOAD_READY(rdy[1]), .SD(sd[1]), .SEN(sen[1]),
        .BUSY(busy[1]), .DONE(done[1]));

    en_serial_tx #(.WIDTH(8), .GAP(0), .MSB_FIRST(1)) u2 (
        .CLK(clk), .RST(rst), .DIN(din[2]), .LOAD_VALID(lv[2]),
        .LOAD_READY(rdy[2]), .SD(sd[2]), .SEN(sen[2]),
        .BUSY(busy[2]), .DONE(done[2]));

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic obs, input logic exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    // Checks the NB SEN cycles of one word, starting in the current cycle.
    task automatic word_bits(input int u, input logic [7:0] w, input bit msb);
        logic eb;
        for (int i = 0; i < NB; i++) begin
            if (i >= 8) eb = ^w;
            else if (msb) eb = w[7-i];
            else eb = w[i];
            chk($sformatf("u%0d_sen_b%0d", u, i), sen[u], 1'b1);
            chk($sformatf("u%0d_sd_b%0d", u, i), sd[u], eb);
            chk($sformatf("u%0d_rdy_b%0d", u, i), rdy[u], 1'b0);
            chk($sformatf("u%0d_busy_b%0d", u, i), busy[u], 1'b1);
            chk($sformatf("u%0d_done_b%0d", u, i), done[u], 1'b0);
            step();
        end
    endtask

    initial begin
        din[0] = 8'h00;
        din[1] = 8'h00;
        din[2] = 8'h00;
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        chk("rst_sen", sen[0], 1'b0);
        chk("rst_sd", sd[0], 1'b0);
        chk("rst_busy", busy[0], 1'b0);
        chk("rst_done", done[0], 1'b0);
        chk("rst_rdy", rdy[0], 1'b1);

        // Single word MSB first, GAP=1
        lv[0] = 1'b1;
        din[0] = 8'hA5;
        step();
        lv[0] = 1'b0;
        word_bits(0, 8'hA5, 1'b1);
        chk("a5_gap_sen", sen[0], 1'b0);
        chk("a5_gap_done", done[0], 1'b1);
        chk("a5_gap_rdy", rdy[0], 1'b0);
        chk("a5_gap_busy", busy[0], 1'b1);
        step();
        chk("a5_end_rdy", rdy[0], 1'b1);
        chk("a5_end_busy", busy[0], 1'b0);
        chk("a5_end_done", done[0], 1'b0);
        chk("a5_end_sen", sen[0], 1'b0);

        // LSB first
        lv[1] = 1'b1;
        din[1] = 8'h01;
        step();
        lv[1] = 1'b0;
        word_bits(1, 8'h01, 1'b0);
        chk("lsb_gap_sen", sen[1], 1'b0);
        chk("lsb_gap_done", done[1], 1'b1);
        step();
        chk("lsb_end_rdy", rdy[1], 1'b1);

        // Back-to-back with GAP=0, valid held
        lv[2] = 1'b1;
        din[2] = 8'hFF;
        step();
        din[2] = 8'h00;
        word_bits(2, 8'hFF, 1'b1);
        chk("b2b_idle_sen", sen[2], 1'b0);
        chk("b2b_idle_done", done[2], 1'b1);
        chk("b2b_idle_rdy", rdy[2], 1'b1);
        chk("b2b_idle_busy", busy[2], 1'b0);
        step();
        din[2] = 8'hFF;
        lv[2] = 1'b0;
        word_bits(2, 8'h00, 1'b1);
        chk("b2b_end_sen", sen[2], 1'b0);
        chk("b2b_end_done", done[2], 1'b1);
        chk("b2b_end_rdy", rdy[2], 1'b1);
        step();
        chk("b2b_after_sen", sen[2], 1'b0);
        chk("b2b_after_done", done[2], 1'b0);

        // Handshake stall: valid held across the word and gap
        lv[0] = 1'b1;
        din[0] = 8'h3C;
        step();
        din[0] = 8'hFF;
        word_bits(0, 8'h3C, 1'b1);
        chk("stall_gap_rdy", rdy[0], 1'b0);
        chk("stall_gap_sen", sen[0], 1'b0);
        step();
        chk("stall_idle_rdy", rdy[0], 1'b1);
        chk("stall_idle_sen", sen[0], 1'b0);
        step();
        lv[0] = 1'b0;
        chk("stall_acc_sen", sen[0], 1'b1);
        chk("stall_acc_sd", sd[0], 1'b1);
        chk("stall_acc_rdy", rdy[0], 1'b0);
        step();
        step();

        // Reset mid-word
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        chk("mid_rst_sen", sen[0], 1'b0);
        chk("mid_rst_busy", busy[0], 1'b0);
        chk("mid_rst_rdy", rdy[0], 1'b1);
        chk("mid_rst_done", done[0], 1'b0);
        for (int i = 0; i < 10; i++) begin
            step();
            chk($sformatf("post_rst_sen%0d", i), sen[0], 1'b0);
        end

`ifdef PARITY_EN
        lv[0] = 1'b1;
        din[0] = 8'h07;
        step();
        lv[0] = 1'b0;
        word_bits(0, 8'h07, 1'b1);
        chk("par07_done", done[0], 1'b1);
        step();
        lv[0] = 1'b1;
        din[0] = 8'h03;
        step();
        lv[0] = 1'b0;
        word_bits(0, 8'h03, 1'b1);
        chk("par03_done", done[0], 1'b1);
        step();
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
